// File: rtl/hex_display_scheduler_pkg.sv
// Shared constants and state encoding for the HEX display scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package hex_ctrl_pkg;

    localparam int          NIBBLE_W  = 4;
    localparam int          SEG_W     = 7;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

endpackage

// File: rtl/hex_display_scheduler_if.sv
// Producer-to-scheduler value handshake: packed nibbles plus blanking request.
// Latency: none (wires only).
// Backpressure: producer holds value_valid and value_in until value_ready is seen high.
interface hex_display_scheduler_if #(
    parameter int NUM_DIGITS = 6
);
    import hex_ctrl_pkg::*;

    logic [NIBBLE_W*NUM_DIGITS-1:0] value_in;
    logic                           value_valid;
    logic                           value_ready;
    logic                           blank_lz;

    modport master (
        output value_in,
        output value_valid,
        output blank_lz,
        input  value_ready
    );

    modport slave (
        input  value_in,
        input  value_valid,
        input  blank_lz,
        output value_ready
    );

endinterface

// File: rtl/hex_display_scheduler_to_seven_digit.sv
// Shared hex-to-7-segment decoder, active-low, bit order g..a.
// Latency: combinational.
// Backpressure: none; codes above 0xF decode to a blank digit.
module to_seven_digit (
    input  logic [6:0] digit,
    output logic [6:0] seg
);

    // Standard hex glyph lookup; anything outside 0..F shows nothing.
    always_comb begin
        seg = 7'b1111111;
        case (digit)
            7'h00: seg = 7'b1000000;
            7'h01: seg = 7'b1111001;
            7'h02: seg = 7'b0100100;
            7'h03: seg = 7'b0110000;
            7'h04: seg = 7'b0011001;
            7'h05: seg = 7'b0010010;
            7'h06: seg = 7'b0000010;
            7'h07: seg = 7'b1111000;
            7'h08: seg = 7'b0000000;
            7'h09: seg = 7'b0010000;
            7'h0A: seg = 7'b0001000;
            7'h0B: seg = 7'b0000011;
            7'h0C: seg = 7'b1000110;
            7'h0D: seg = 7'b0100001;
            7'h0E: seg = 7'b0000110;
            7'h0F: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/hex_display_scheduler.sv
// Scans one shared 7-seg decoder across NUM_DIGITS HEX positions, MSD first, with leading-zero blanking.
// Latency: NUM_DIGITS+2 edges from acceptance to value_ready high again; update_done pulses the cycle after the last digit write.
// Backpressure: value_ready low while scanning; optional blink overlay when HEX_BLINK_EN is defined.
module hex_display_scheduler
    import hex_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                         clk,
    input  logic                         reset,
    hex_display_scheduler_if.slave       bus,
    input  logic                         blink_en,
    output logic [SEG_W*NUM_DIGITS-1:0]  hex_out,
    output logic                         busy,
    output logic                         update_done
);

    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t                               state_q, state_d;
    logic                                 ready_q, ready_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic                                 seen_q, seen_d;
    logic [NUM_DIGITS-1:0][NIBBLE_W-1:0]  shadow_q;
    logic                                 blank_sh_q;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]     seg_q;

    logic                                 accept;
    logic                                 seg_we;
    logic [SEG_W-1:0]                     seg_wdat;
    logic [SEG_W-1:0]                     dec_seg;
    logic [NIBBLE_W-1:0]                  cur_nib;

    // The nibble under the scan index feeds the single shared decoder.
    assign cur_nib = shadow_q[idx_q];

    to_seven_digit u_dec (
        .digit ({3'b000, cur_nib}),
        .seg   (dec_seg)
    );

    // Next-state, handshake and digit-write decisions.
    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        idx_d    = idx_q;
        seen_d   = seen_q;
        accept   = 1'b0;
        seg_we   = 1'b0;
        seg_wdat = dec_seg;
        case (state_q)
            IDLE: begin
                if (ready_q && bus.value_valid) begin
                    accept  = 1'b1;
                    ready_d = 1'b0;
                    idx_d   = LAST_IDX;
                    seen_d  = 1'b0;
                    state_d = SCAN;
                end else begin
                    ready_d = 1'b1;
                end
            end
            SCAN: begin
                seg_we = 1'b1;
                // Digit 0 is never blanked so an all-zero value still reads "0".
                if (blank_sh_q && !seen_q && (cur_nib == '0) && (idx_q != '0)) begin
                    seg_wdat = SEG_BLANK;
                end
                seen_d = seen_q | (cur_nib != '0);
                if (idx_q == '0) begin
                    idx_d   = LAST_IDX;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            idx_q   <= LAST_IDX;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            idx_q   <= idx_d;
            seen_q  <= seen_d;
        end
    end

    // Shadow copy of the accepted value so the producer may move on during a scan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q   <= '0;
            blank_sh_q <= 1'b0;
        end else if (accept) begin
            shadow_q   <= bus.value_in;
            blank_sh_q <= bus.blank_lz;
        end
    end

    // Segment registers: one digit rewritten per scan cycle, the rest hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q <= {NUM_DIGITS{SEG_BLANK}};
        end else if (seg_we) begin
            seg_q[idx_q] <= seg_wdat;
        end
    end

    assign bus.value_ready = ready_q;
    assign busy            = (state_q != IDLE);
    assign update_done     = (state_q == DONE);

`ifdef HEX_BLINK_EN
    localparam int               CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] blink_cnt_q;
    logic             blink_phase_q;

    // Free-running blink timebase; phase flips every BLINK_DIV cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == CNT_LAST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + CNT_W'(1);
        end
    end

    // Blink masks the pins only; stored digits stay untouched.
    assign hex_out = (blink_en && blink_phase_q) ? {NUM_DIGITS{SEG_BLANK}} : seg_q;
`else
    logic unused_blink;
    assign unused_blink = blink_en & (BLINK_DIV > 0);
    assign hex_out      = seg_q;
`endif

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Self-checking bench for hex_display_scheduler with NUM_DIGITS=4.
// Directed scenarios pin exact glyphs; a timeline model checks every cycle under random traffic.
// Inputs change 2 time units after the rising edge; outputs are compared on the falling edge.
module tb_hex_display_scheduler;
    import hex_ctrl_pkg::*;

    localparam int ND   = 4;
    localparam int BDIV = 4;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        blink_en = 1'b0;
    logic [27:0] hex_out;
    logic        busy;
    logic        update_done;
    logic        chk_on   = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    hex_display_scheduler_if #(.NUM_DIGITS(ND)) bus ();

    hex_display_scheduler #(
        .NUM_DIGITS (ND),
        .BLINK_DIV  (BDIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .blink_en    (blink_en),
        .hex_out     (hex_out),
        .busy        (busy),
        .update_done (update_done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Timeline view: phase 0 = idle, 1..ND = write digit ND-phase on that edge, ND+1 = done cycle.
    logic [6:0]  m_disp [ND];
    logic        m_ready = 1'b0;
    int          m_phase = 0;
    int          m_edges = 0;
    logic [15:0] m_val   = '0;
    logic        m_blank = 1'b0;

    // Leading zero: this nibble and everything above it is zero.
    function automatic logic [6:0] expect_digit(input logic [15:0] v, input logic b, input int d);
        logic [15:0] hi;
        hi = v >> (4 * d);
        if (b && d != 0 && hi == 16'h0) return SEG_BLANK;
        return GLYPH[hi[3:0]];
    endfunction

    function automatic logic [27:0] exp_hex();
        logic [27:0] r;
        for (int d = 0; d < ND; d++) r[7*d +: 7] = m_disp[d];
`ifdef HEX_BLINK_EN
        if (blink_en && ((m_edges / BDIV) % 2 == 1)) r = '1;
`endif
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < ND; d++) m_disp[d] = SEG_BLANK;
            m_ready = 1'b0;
            m_phase = 0;
            m_edges = 0;
        end else begin
            m_edges++;
            if (m_phase == 0) begin
                if (m_ready && bus.value_valid) begin
                    m_val   = bus.value_in;
                    m_blank = bus.blank_lz;
                    m_ready = 1'b0;
                    m_phase = 1;
                end else begin
                    m_ready = 1'b1;
                end
            end else if (m_phase <= ND) begin
                m_disp[ND - m_phase] = expect_digit(m_val, m_blank, ND - m_phase);
                m_phase++;
            end else begin
                m_phase = 0;
                m_ready = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_hex_out",     {4'h0, hex_out},    {4'h0, exp_hex()});
            chk("cyc_value_ready", {31'h0, bus.value_ready}, {31'h0, m_ready});
            chk("cyc_busy",        {31'h0, busy},       {31'h0, (m_phase != 0)});
            chk("cyc_update_done", {31'h0, update_done}, {31'h0, (m_phase == ND + 1)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Raise valid and hold it until the accepting edge (E0); returns at E0+2.
    task automatic send(input logic [15:0] v, input logic b);
        bit ok;
        ok = 0;
        bus.value_in    = v;
        bus.blank_lz    = b;
        bus.value_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.value_ready) ok = 1;
            tick();
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bus.value_valid = 1'b0;
        bus.value_in    = '0;
        bus.blank_lz    = 1'b0;
        #1 reset = 1'b1;
        #1 chk_on = 1'b1;
        chk("rst_hex",   {4'h0, hex_out}, {4'h0, 28'hFFFFFFF});
        chk("rst_ready", {31'h0, bus.value_ready}, 32'd0);
        chk("rst_busy",  {31'h0, busy}, 32'd0);
        chk("rst_done",  {31'h0, update_done}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        tick();
        chk("ready_after_release", {31'h0, bus.value_ready}, 32'd1);

        // 00A3 with blanking
        send(16'h00A3, 1'b1);
        bus.value_valid = 1'b0;
        repeat (3) tick();
        chk("a3_no_early_done", {31'h0, update_done}, 32'd0);
        tick();
        chk("a3_hex",  {4'h0, hex_out}, {4'h0, 7'h7F, 7'h7F, 7'h08, 7'h30});
        chk("a3_done", {31'h0, update_done}, 32'd1);
        chk("a3_ready_low", {31'h0, bus.value_ready}, 32'd0);
        tick();
        chk("a3_ready_back", {31'h0, bus.value_ready}, 32'd1);
        chk("a3_done_gone",  {31'h0, update_done}, 32'd0);

        // all zero, blank on and off
        send(16'h0000, 1'b1);
        bus.value_valid = 1'b0;
        repeat (ND + 1) tick();
        chk("zero_blank", {4'h0, hex_out}, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        send(16'h0000, 1'b0);
        bus.value_valid = 1'b0;
        repeat (ND + 1) tick();
        chk("zero_noblank", {4'h0, hex_out}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h40});

        // value changes under a held valid during the scan
        send(16'h1234, 1'b0);
        bus.value_in = 16'hFFFF;
        repeat (ND) tick();
        chk("hold_1234", {4'h0, hex_out}, {4'h0, 7'h79, 7'h24, 7'h30, 7'h19});
        tick();
        chk("hold_ready", {31'h0, bus.value_ready}, 32'd1);
        tick();
        chk("ffff_accepted", {31'h0, busy}, 32'd1);
        bus.value_valid = 1'b0;
        repeat (ND + 1) tick();
        chk("ffff_hex", {4'h0, hex_out}, {4'h0, 7'h0E, 7'h0E, 7'h0E, 7'h0E});

        // reset in the middle of a scan
        send(16'h5678, 1'b0);
        bus.value_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        #1;
        chk("midrst_hex",  {4'h0, hex_out}, {4'h0, 28'hFFFFFFF});
        chk("midrst_busy", {31'h0, busy}, 32'd0);
        chk("midrst_done", {31'h0, update_done}, 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        tick();
        chk("midrst_ready", {31'h0, bus.value_ready}, 32'd1);
        send(16'h0BEF, 1'b1);
        bus.value_valid = 1'b0;
        repeat (ND + 1) tick();
        chk("after_rst_hex", {4'h0, hex_out}, {4'h0, 7'h7F, 7'h03, 7'h06, 7'h0E});

        // random traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 199) == 0) reset = 1'b1;
            bus.value_valid = ($urandom_range(0, 2) != 0);
            bus.value_in    = 16'($urandom) >> (4 * $urandom_range(0, 4));
            bus.blank_lz    = $urandom_range(0, 1) == 1;
            blink_en        = ($urandom_range(0, 3) == 0);
        end

        reset           = 1'b0;
        bus.value_valid = 1'b0;
        repeat (10) tick();
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
